// File: rtl/switches_op_pkg.sv
// Shared definitions for the switch-to-op controller.
//   OP_CALC..OP_INPUT : op codes selected by switches 0..3
//   op_invalid()      : invalid op code for a given switch count (== n_sw)
//   op_t              : op code type for the default four-switch build
//   commit_state_e    : commit FSM states (IDLE = op invalid, ACTIVE = op valid)
package switches_op_pkg;

    localparam int unsigned OP_CALC  = 0;
    localparam int unsigned OP_SHOW  = 1;
    localparam int unsigned OP_GEN   = 2;
    localparam int unsigned OP_INPUT = 3;

    localparam int unsigned N_SW_DEFAULT = 4;

    typedef logic [$clog2(N_SW_DEFAULT+1)-1:0] op_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } commit_state_e;

    function automatic int unsigned op_invalid(input int unsigned n_sw);
        return n_sw;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-FF synchroniser followed by a stability counter.
//   clk, rst : clock, synchronous active-high reset
//   sw_i     : raw asynchronous switch level
//   db_o     : debounced level; follows s2 only after DEBOUNCE_CYCLES
//              consecutive cycles of disagreement
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic db_o
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            db_o <= 1'b0;
        end else begin
            s1 <= sw_i;
            s2 <= s1;
            // Any return to the accepted level discards the partial count.
            if (s2 == db_o) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db_o <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switches_op_ctrl.sv
// Debounced slide-switch to op-code controller.
//   clk, rst    : clock, synchronous active-high reset
//   sw_i        : raw switch levels, bit i selects op i
//   busy_i      : downstream engine busy, freezes op_o while high
//   op_o        : committed op code, N_SW means invalid
//   op_valid_o  : registered (op_o != N_SW)
//   op_change_o : one-cycle pulse in the cycle op_o takes a new value
//   pending_o   : decoded op differs from op_o but is held off by busy_i
// Build option SWITCHES_OP_PRIORITY_EN: several set switches resolve to the
// lowest index instead of being treated as invalid.
module switches_op_ctrl
    import switches_op_pkg::*;
#(
    parameter  int unsigned N_SW            = 4,
    parameter  int unsigned DEBOUNCE_CYCLES = 20000,
    localparam int unsigned OP_W            = $clog2(N_SW + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_i,
    input  logic            busy_i,
    output logic [OP_W-1:0] op_o,
    output logic            op_valid_o,
    output logic            op_change_o,
    output logic            pending_o
);

    localparam logic [OP_W-1:0] OP_INVALID = OP_W'(op_invalid(N_SW));

    logic [N_SW-1:0] db;
    logic [OP_W-1:0] cand;
    logic [OP_W-1:0] op_q, op_d;
    logic            change_q, change_d;
    commit_state_e   state_q, state_d;

    for (genvar g = 0; g < N_SW; g++) begin : g_db
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .sw_i (sw_i[g]),
            .db_o (db[g])
        );
    end

    always_comb begin
        cand = OP_INVALID;
`ifdef SWITCHES_OP_PRIORITY_EN
        // Descending scan so the lowest set index is written last.
        for (int unsigned i = N_SW; i > 0; i--) begin
            if (db[i-1]) cand = OP_W'(i - 1);
        end
`else
        if ($countones(db) == 1) begin
            for (int unsigned i = 0; i < N_SW; i++) begin
                if (db[i]) cand = OP_W'(i);
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        change_d = 1'b0;
        if (!busy_i && (cand != op_q)) begin
            op_d     = cand;
            change_d = 1'b1;
            state_d  = (cand == OP_INVALID) ? ST_IDLE : ST_ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_INVALID;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            change_q <= change_d;
        end
    end

    assign op_o        = op_q;
    assign op_valid_o  = (state_q == ST_ACTIVE);
    assign op_change_o = change_q;
    assign pending_o   = busy_i && (cand != op_q);

endmodule

// File: tb/tb_switches_op_ctrl.sv
// Bench for switches_op_ctrl with N_SW=4, DEBOUNCE_CYCLES=4.
module tb_switches_op_ctrl;

    localparam int N   = 4;
    localparam int D   = 4;
    localparam int INV = N;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       busy_i = 1'b0;
    logic [3:0] sw_i   = 4'b0001;
    logic [2:0] op_o;
    logic       op_valid_o;
    logic       op_change_o;
    logic       pending_o;

    int tests = 0;
    int fails = 0;

    switches_op_ctrl #(
        .N_SW            (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_i        (sw_i),
        .busy_i      (busy_i),
        .op_o        (op_o),
        .op_valid_o  (op_valid_o),
        .op_change_o (op_change_o),
        .pending_o   (pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the switch level seen by the debouncer lags sw_i by
    // two edges (zero right after reset); a debounced bit flips once the
    // last D seen values all disagree with it.
    function automatic int ref_decode(input logic [3:0] v);
        int n;
        n = $countones(v);
        if (n == 0) return INV;
`ifdef SWITCHES_OP_PRIORITY_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
        if (n != 1) return INV;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return INV;
    endfunction

    typedef struct {
        int op;
        int cyc;
    } ev_t;

    ev_t        sb[$];
    logic [3:0] pipe_q[$];
    logic [3:0] win_q[$];
    logic [3:0] db_m = 4'b0;
    logic [3:0] vis, db_nxt;
    int         op_m = INV;
    int         cand_m;
    int         cyc  = 0;
    bit         all_diff;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pipe_q = {4'b0, 4'b0};
            win_q  = {};
            db_m   = 4'b0;
            op_m   = INV;
        end else begin
            cand_m = ref_decode(db_m);
            if (!busy_i && cand_m != op_m) begin
                op_m = cand_m;
                sb.push_back('{op: op_m, cyc: cyc});
            end
            vis = pipe_q.pop_front();
            pipe_q.push_back(sw_i);
            win_q.push_back(vis);
            if (win_q.size() > D) void'(win_q.pop_front());
            db_nxt = db_m;
            for (int i = 0; i < N; i++) begin
                all_diff = (win_q.size() == D);
                foreach (win_q[k]) if (win_q[k][i] == db_m[i]) all_diff = 1'b0;
                if (all_diff) db_nxt[i] = ~db_m[i];
            end
            db_m = db_nxt;
        end
    end

    // Monitor: per-cycle state against the model, change pulses against the
    // scoreboard (value and cycle).
    ev_t e;
    int  exp_pend;
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("op_o", int'(op_o), op_m);
            chk("op_valid_o", int'(op_valid_o), int'(op_m != INV));
            exp_pend = int'(busy_i && (ref_decode(db_m) != op_m));
            chk("pending_o", int'(pending_o), exp_pend);
            if (op_change_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_change", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("change_op", int'(op_o), e.op);
                    chk("change_cycle", cyc, e.cyc);
                end
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("missing_change_cycle", cyc + 1000, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic wait_change(input int limit, output int k);
        k = 0;
        for (int j = 1; j <= limit; j++) begin
            tick();
            if (op_change_o) begin
                k = j;
                break;
            end
        end
    endtask

    int k;
    int pulses;
    int r;

    initial begin
        // Reset held 3 cycles with a valid switch set
        rst  = 1'b1;
        sw_i = 4'b0001;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("rst_op", int'(op_o), 4);
            chk("rst_change", int'(op_change_o), 0);
        end
        rst = 1'b0;
        wait_change(12, k);
        chk("rst_release_latency", k, 7);
        chk("rst_release_op", int'(op_o), 0);
        tick();
        chk("single_pulse", int'(op_change_o), 0);

        // Bounce on bit 1
        sw_i = 4'b0000;
        ticks(10);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            sw_i[1] = ((c / 2) % 2 == 0);
            tick();
            if (op_change_o) pulses++;
        end
        chk("bounce_pulses", pulses, 0);
        chk("bounce_op", int'(op_o), 4);
        sw_i = 4'b0010;
        wait_change(12, k);
        chk("bounce_latency", k, 7);
        chk("bounce_op_final", int'(op_o), 1);

        // Multi-hot
        sw_i = 4'b0110;
        ticks(10);
`ifdef SWITCHES_OP_PRIORITY_EN
        chk("multihot_op", int'(op_o), 1);
        chk("multihot_valid", int'(op_valid_o), 1);
`else
        chk("multihot_op", int'(op_o), 4);
        chk("multihot_valid", int'(op_valid_o), 0);
`endif

        // Busy hold
        sw_i = 4'b0001;
        ticks(10);
        chk("busy_pre_op", int'(op_o), 0);
        busy_i = 1'b1;
        sw_i   = 4'b1000;
        ticks(12);
        chk("busy_hold_op", int'(op_o), 0);
        chk("busy_pending", int'(pending_o), 1);
        busy_i = 1'b0;
        tick();
        chk("busy_release_op", int'(op_o), 3);
        chk("busy_release_pulse", int'(op_change_o), 1);
        tick();
        chk("busy_release_single", int'(op_change_o), 0);
        chk("busy_release_pending", int'(pending_o), 0);

        // Overwrite while busy
        busy_i = 1'b1;
        pulses = 0;
        sw_i   = 4'b0010;
        for (int j = 0; j < 10; j++) begin tick(); if (op_change_o) pulses++; end
        sw_i = 4'b0100;
        for (int j = 0; j < 10; j++) begin tick(); if (op_change_o) pulses++; end
        busy_i = 1'b0;
        tick();
        if (op_change_o) pulses++;
        chk("overwrite_op", int'(op_o), 2);
        tick();
        if (op_change_o) pulses++;
        chk("overwrite_pulses", pulses, 1);

        // Reset while pending
        busy_i = 1'b1;
        sw_i   = 4'b1000;
        ticks(10);
        chk("mid_pending", int'(pending_o), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_op", int'(op_o), 4);
        chk("mid_rst_pending", int'(pending_o), 0);
        chk("mid_rst_change", int'(op_change_o), 0);
        rst    = 1'b0;
        busy_i = 1'b0;
        wait_change(12, k);
        chk("mid_rst_relatency", k, 7);
        chk("mid_rst_reop", int'(op_o), 3);

        // Randomised traffic
        for (int j = 0; j < 3000; j++) begin
            if (rst) rst = 1'b0;
            r = int'($urandom_range(0, 999));
            if (r < 3) rst = 1'b1;
            else if (r < 120) begin
                if ($urandom_range(0, 1) == 0) sw_i = 4'(1 << $urandom_range(0, 3));
                else sw_i = 4'($urandom_range(0, 15));
            end else if (r < 180) begin
                sw_i[$urandom_range(0, 3)] ^= 1'b1;
            end
            if ($urandom_range(0, 9) == 0) busy_i = ~busy_i;
            tick();
        end
        rst    = 1'b0;
        busy_i = 1'b0;
        ticks(12);

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switches_op_ctrl.md
Name: switches_op_ctrl

Overview:
- Parametrised successor to the combinational switch-to-op decoder.
- Synchronises and debounces N_SW slide switches, then checks the debounced vector is one-hot. Switch i maps to op code i; any other pattern maps to OP_INVALID = N_SW.
- Registers the resulting op and holds it while the downstream matrix engine reports busy. Emits a one-cycle change strobe to the top-level mode FSM.

Parameters:
- N_SW, 4, number of mode switches (≥2).
- DEBOUNCE_CYCLES, 20000, consecutive stable cycles required before a switch change is accepted (≥1).
- OP_W, $clog2(N_SW+1), op code width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw_i  in  N_SW  raw asynchronous switch levels; bit i selects op i
- busy_i  in  1  downstream engine busy; freezes op_o while high
- op_o  out  OP_W  committed op code; N_SW = invalid
- op_valid_o  out  1  high when op_o != OP_INVALID
- op_change_o  out  1  one-cycle pulse on the cycle op_o takes a new value
- pending_o  out  1  decoded op differs from op_o and is held off by busy_i

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it dominates all other inputs.
- Reset values:
  - sync regs = 0, debounced vector = 0, counters = 0
  - op_o = N_SW, op_valid_o = 0, op_change_o = 0, pending_o = 0
- Synchroniser: 2-FF per bit (s1, s2).
- Debounce, per bit, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s2 == db[i], the counter clears to 0.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, db[i] <= s2 and the counter clears.
  - Any glitch that returns s2 to db[i] clears the counter, so partial counts never carry over.
- Decode (combinational from db):
  - Exactly one bit i set -> cand = i.
  - All-zero or multiple bits set -> cand = N_SW.
- Commit FSM, states IDLE (op_o invalid) and ACTIVE (op_o valid):
  - If busy_i == 0 and cand != op_o: op_o <= cand, op_change_o = 1 for that cycle. State follows op_valid.
  - If busy_i == 1: op_o holds; pending_o = (cand != op_o).
  - On busy_i falling, a still-differing cand commits on the next edge.
  - A cand that changes again while held overwrites the earlier one. Only the latest cand commits; the intermediate one is never seen.
- Latency: a clean switch edge that is then held stable changes op_o DEBOUNCE_CYCLES+3 edges after the first edge on which sw_i shows the new level (2 sync + DEBOUNCE_CYCLES + 1 commit).
- op_valid_o is a registered copy of (op_o != N_SW), updated in the same cycle as op_o.
- Reset mid-debounce or while pending: all in-flight state is discarded; no op_change_o pulse is issued on reset.
- Simultaneous events: busy_i rising on the same cycle that cand changes blocks the commit.

Optional Feature:
- Macro SWITCHES_OP_PRIORITY_EN.
- Defined: multiple debounced switches high resolve to the lowest set index (priority encode). Only all-zero yields OP_INVALID.
- Undefined: strict one-hot rule as above.

Decomposition:
- switches_op_pkg holds:
  - the OP_CALC=0, OP_SHOW=1, OP_GEN=2, OP_INPUT=3 localparams
  - a function op_invalid(N_SW) returning N_SW
  - the op_t typedef for the default N_SW=4
- Sub-module sw_debounce: one-bit 2-FF sync plus counter, parameter DEBOUNCE_CYCLES. Instantiated N_SW times in a generate loop.

Test Plan (N_SW=4, DEBOUNCE_CYCLES=4):
- Reset: hold rst 3 cycles with sw_i=4'b0001 -> op_o=4, op_valid_o=0, op_change_o=0 throughout. After release, op_o=0 exactly 7 edges later with a single op_change_o pulse.
- Bounce: sw_i toggles 0/1 on bit 1 every 2 cycles for 20 cycles, then holds 1 -> op_o stays 4 during bouncing, becomes 1 seven edges after the final rise.
- Multi-hot: sw_i=4'b0110 stable -> op_o=4, op_valid_o=0. With SWITCHES_OP_PRIORITY_EN defined -> op_o=1.
- Busy hold: op_o=0, busy_i=1, sw_i changes 0001->1000 -> op_o stays 0, pending_o=1 after debounce. Drop busy_i -> op_o=3 on the next edge, single pulse, pending_o=0.
- Overwrite while busy: busy_i=1, sw_i goes 0010 then 0100, each debounced -> on busy_i release op_o=2 directly, no intermediate op 1.
- Reset mid-pending: pending_o=1, assert rst one cycle -> op_o=4, pending_o=0, no pulse. Then re-debounces from scratch.
